// File: rtl/fir_sched_pkg.sv
// Shared scheduler types: FSM state encoding and channel-index width.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_t;

    // Channel index width; a single channel still needs one bit of index.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at last_grant+1 and wraps to 0.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]           req,
    input  logic [ch_width(NUM_CH)-1:0] last_grant,
    output logic [NUM_CH-1:0]           gnt,
    output logic [ch_width(NUM_CH)-1:0] gnt_idx,
    output logic                        gnt_vld
);

    localparam int CH_W = ch_width(NUM_CH);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        // First pass scans channels above last_grant; second pass wraps from channel 0.
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_vld && req[k] && (k > int'(last_grant))) begin
                gnt[k]  = 1'b1;
                gnt_idx = CH_W'(k);
                gnt_vld = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_vld && req[k] && (k <= int'(last_grant))) begin
                gnt[k]  = 1'b1;
                gnt_idx = CH_W'(k);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Shares one MAC engine among NUM_CH decimated filter channels (IDLE -> ISSUE -> WAIT).
// Define FIR_SCHED_TIMEOUT_EN to abandon a MAC request after TIMEOUT_CYCLES cycles in WAIT.
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int NUM_BITS       = 24,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_CH-1:0]              ch_tick_i,
    input  logic [NUM_CH*NUM_BITS-1:0]     ch_data_i,
    output logic                           mac_start_o,
    output logic [ch_width(NUM_CH)-1:0]    mac_ch_o,
    output logic signed [NUM_BITS-1:0]     mac_data_o,
    input  logic                           mac_done_i,
    input  logic signed [NUM_BITS-1:0]     mac_result_i,
    output logic [NUM_CH*NUM_BITS-1:0]     result_o,
    output logic [NUM_CH-1:0]              result_valid_o,
    output logic                           frame_done_o,
    output logic [NUM_CH-1:0]              overrun_o,
    output logic                           timeout_o,
    input  logic                           clear_i,
    output logic                           busy_o
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam logic [NUM_CH-1:0] ALL_CH = '1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    sched_state_t               state, state_nxt;
    logic [NUM_CH-1:0]          pending, frame_mask, grant_oh;
    logic [NUM_CH-1:0]          arb_gnt, issue_clr, tick_overrun;
    logic [CH_W-1:0]            arb_idx, grant, last_grant;
    logic                       arb_vld, issue, capture, expire;
    logic signed [NUM_BITS-1:0] hold [NUM_CH];

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (pending),
        .last_grant(last_grant),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_vld   (arb_vld)
    );

`ifdef FIR_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt;

    assign expire = (state == ST_WAIT) && !mac_done_i && (wait_cnt == TO_LAST);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wait_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (state == ST_WAIT && !mac_done_i && !expire) wait_cnt <= wait_cnt + TO_W'(1);
            else                                           wait_cnt <= '0;
            timeout_o <= (timeout_o & ~clear_i) | expire;
        end
    end
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_vld) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (mac_done_i || expire) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        issue   = (state == ST_ISSUE);
        capture = (state == ST_WAIT) && mac_done_i;
        busy_o  = (state != ST_IDLE);
    end

    // A tick on the channel being issued refills pending and is not an overrun.
    assign issue_clr    = issue ? (grant_oh & ~ch_tick_i) : '0;
    assign tick_overrun = ch_tick_i & pending & ~(issue ? grant_oh : '0);

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_tick_i[c]) hold[c] <= ch_data_i[c*NUM_BITS +: NUM_BITS];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pending        <= '0;
            frame_mask     <= '0;
            grant          <= '0;
            grant_oh       <= '0;
            last_grant     <= CH_W'(NUM_CH - 1);
            mac_start_o    <= 1'b0;
            mac_ch_o       <= '0;
            mac_data_o     <= '0;
            result_o       <= '0;
            result_valid_o <= '0;
            frame_done_o   <= 1'b0;
            overrun_o      <= '0;
        end else begin
            pending        <= (pending & ~issue_clr) | ch_tick_i;
            overrun_o      <= (overrun_o & ~{NUM_CH{clear_i}}) | tick_overrun;
            mac_start_o    <= issue;
            result_valid_o <= '0;
            frame_done_o   <= 1'b0;
            if (state == ST_IDLE && arb_vld) begin
                grant    <= arb_idx;
                grant_oh <= arb_gnt;
            end
            if (issue) begin
                mac_ch_o   <= grant;
                mac_data_o <= hold[grant];
            end
            if (capture) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (grant_oh[c]) result_o[c*NUM_BITS +: NUM_BITS] <= mac_result_i;
                end
                result_valid_o <= grant_oh;
                last_grant     <= grant;
                if ((frame_mask | grant_oh) == ALL_CH) begin
                    frame_done_o <= 1'b1;
                    frame_mask   <= '0;
                end else begin
                    frame_mask <= frame_mask | grant_oh;
                end
            end
            if (expire) last_grant <= grant;
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler; vectors carry hand-computed expected outputs.
module tb_fir_mac_scheduler;

    localparam int NUM_CH = 4;
    localparam int NB     = 24;
    localparam int TO     = 16;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic [3:0]       tick    = '0;
    logic [95:0]      ch_data = '0;
    logic             done    = 1'b0;
    logic [23:0]      mres    = '0;
    logic             clr     = 1'b0;
    logic             start;
    logic [1:0]       mch;
    logic [23:0]      mdata;
    logic [95:0]      res;
    logic [3:0]       rv;
    logic             fd;
    logic [3:0]       ovr;
    logic             tmo;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_mac_scheduler #(.NUM_CH(NUM_CH), .NUM_BITS(NB), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_i(reset_n), .ch_tick_i(tick), .ch_data_i(ch_data),
        .mac_start_o(start), .mac_ch_o(mch), .mac_data_o(mdata), .mac_done_i(done),
        .mac_result_i(mres), .result_o(res), .result_valid_o(rv), .frame_done_o(fd),
        .overrun_o(ovr), .timeout_o(tmo), .clear_i(clr), .busy_o(busy)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  tick;
        logic [23:0] d;
        logic        done;
        logic [23:0] res;
        logic        clr;
        logic        e_start;
        logic [1:0]  e_ch;
        logic [23:0] e_data;
        logic        e_busy;
        logic [3:0]  e_rv;
        logic        e_fd;
        logic [3:0]  e_ovr;
        int          rch;
        logic [23:0] e_res;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [3:0] tk, logic [23:0] d, logic dn, logic [23:0] r,
                                logic cl, logic es, logic [1:0] ech, logic [23:0] edat, logic eb,
                                logic [3:0] erv, logic efd, logic [3:0] eovr, int rch, logic [23:0] eres);
        vec_t v;
        v.rst = rst; v.tick = tk; v.d = d; v.done = dn; v.res = r; v.clr = cl;
        v.e_start = es; v.e_ch = ech; v.e_data = edat; v.e_busy = eb; v.e_rv = erv;
        v.e_fd = efd; v.e_ovr = eovr; v.rch = rch; v.e_res = eres;
        return v;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Channel c receives sample d + c.
    task automatic drive(input logic [3:0] tk, input logic [23:0] d, input logic dn,
                         input logic [23:0] r, input logic cl);
        tick = tk;
        for (int c = 0; c < NUM_CH; c++) ch_data[c*NB +: NB] = d + 24'(c);
        done = dn;
        mres = r;
        clr  = cl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'h0, 24'h0, 1'b0, 24'h0, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 96'(start), 96'(0));
        chk({tag, "_ch"},    96'(mch),   96'(0));
        chk({tag, "_data"},  96'(mdata), 96'(0));
        chk({tag, "_res"},   res,        96'(0));
        chk({tag, "_rv"},    96'(rv),    96'(0));
        chk({tag, "_fd"},    96'(fd),    96'(0));
        chk({tag, "_ovr"},   96'(ovr),   96'(0));
        chk({tag, "_tmo"},   96'(tmo),   96'(0));
        chk({tag, "_busy"},  96'(busy),  96'(0));
    endtask

    initial begin
        // Single ch0 sample, MAC answers 5 cycles after start; a stray done afterwards is ignored.
        tbl.push_back(mk(1, 4'h1, 24'h123, 0, 0,        0, 0, 0, 24'h0,   0, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 0, 0, 24'h0,   1, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 1, 0, 24'h123, 1, 4'h0, 0, 4'h0, 0, 24'h0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 4'h0, 24'h0, 0, 0,      0, 0, 0, 24'h123, 1, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'h456,  0, 0, 0, 24'h123, 0, 4'h1, 0, 4'h0, 0, 24'h456));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'hBAD,  0, 0, 0, 24'h123, 0, 4'h0, 0, 4'h0, 0, 24'h456));
        // All four channels tick together: grants 0..3, frame_done with the ch3 result.
        tbl.push_back(mk(1, 4'hF, 24'h10,  0, 0,        0, 0, 0, 24'h0,   0, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 0, 0, 24'h0,   1, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 1, 0, 24'h10,  1, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'hA0,   0, 0, 0, 24'h10,  0, 4'h1, 0, 4'h0, 0, 24'hA0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 0, 0, 24'h10,  1, 4'h0, 0, 4'h0, 0, 24'hA0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 1, 1, 24'h11,  1, 4'h0, 0, 4'h0, 1, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'hA1,   0, 0, 1, 24'h11,  0, 4'h2, 0, 4'h0, 1, 24'hA1));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 0, 1, 24'h11,  1, 4'h0, 0, 4'h0, 1, 24'hA1));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 1, 2, 24'h12,  1, 4'h0, 0, 4'h0, 2, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'hA2,   0, 0, 2, 24'h12,  0, 4'h4, 0, 4'h0, 2, 24'hA2));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 0, 2, 24'h12,  1, 4'h0, 0, 4'h0, 2, 24'hA2));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 1, 3, 24'h13,  1, 4'h0, 0, 4'h0, 3, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'hA3,   0, 0, 3, 24'h13,  0, 4'h8, 1, 4'h0, 3, 24'hA3));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 0, 3, 24'h13,  0, 4'h0, 0, 4'h0, 0, 24'hA0));
        // ch2 ticks with 5 then 7 before issue; clear; then tick+clear together keeps the flag.
        tbl.push_back(mk(1, 4'h4, 24'h3,   0, 0,        0, 0, 0, 24'h0,   0, 4'h0, 0, 4'h0, 2, 24'h0));
        tbl.push_back(mk(0, 4'h4, 24'h5,   0, 0,        0, 0, 0, 24'h0,   1, 4'h0, 0, 4'h4, 2, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 1, 2, 24'h7,   1, 4'h0, 0, 4'h4, 2, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'h55,   0, 0, 2, 24'h7,   0, 4'h4, 0, 4'h4, 2, 24'h55));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        1, 0, 2, 24'h7,   0, 4'h0, 0, 4'h0, 2, 24'h55));
        tbl.push_back(mk(0, 4'h2, 24'h8,   0, 0,        0, 0, 2, 24'h7,   0, 4'h0, 0, 4'h0, 2, 24'h55));
        tbl.push_back(mk(0, 4'h2, 24'h8,   0, 0,        1, 0, 2, 24'h7,   1, 4'h0, 0, 4'h2, 2, 24'h55));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 1, 1, 24'h9,   1, 4'h0, 0, 4'h2, 1, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'h99,   0, 0, 1, 24'h9,   0, 4'h2, 0, 4'h2, 1, 24'h99));
        // Tick on the granted channel during ISSUE: old sample goes out, new one is re-issued.
        tbl.push_back(mk(1, 4'h1, 24'h20,  0, 0,        0, 0, 0, 24'h0,   0, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 0, 0, 24'h0,   1, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h1, 24'h30,  0, 0,        0, 1, 0, 24'h20,  1, 4'h0, 0, 4'h0, 0, 24'h0));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'h66,   0, 0, 0, 24'h20,  0, 4'h1, 0, 4'h0, 0, 24'h66));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 0, 0, 24'h20,  1, 4'h0, 0, 4'h0, 0, 24'h66));
        tbl.push_back(mk(0, 4'h0, 24'h0,   0, 0,        0, 1, 0, 24'h30,  1, 4'h0, 0, 4'h0, 0, 24'h66));
        tbl.push_back(mk(0, 4'h0, 24'h0,   1, 24'h77,   0, 0, 0, 24'h30,  0, 4'h1, 0, 4'h0, 0, 24'h77));

        // Reset state, checked before any clock edge.
        #1 reset_n = 1'b0;
        #1 chk_all_zero("por");
        step();
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].tick, tbl[i].d, tbl[i].done, tbl[i].res, tbl[i].clr);
            step();
            chk($sformatf("vec%0d_start", i), 96'(start), 96'(tbl[i].e_start));
            chk($sformatf("vec%0d_ch", i),    96'(mch),   96'(tbl[i].e_ch));
            chk($sformatf("vec%0d_data", i),  96'(mdata), 96'(tbl[i].e_data));
            chk($sformatf("vec%0d_busy", i),  96'(busy),  96'(tbl[i].e_busy));
            chk($sformatf("vec%0d_rv", i),    96'(rv),    96'(tbl[i].e_rv));
            chk($sformatf("vec%0d_fd", i),    96'(fd),    96'(tbl[i].e_fd));
            chk($sformatf("vec%0d_ovr", i),   96'(ovr),   96'(tbl[i].e_ovr));
            chk($sformatf("vec%0d_res", i),   96'(res[tbl[i].rch*NB +: NB]), 96'(tbl[i].e_res));
        end

        // MAC never answers.
        do_reset();
        drive(4'h1, 24'h42, 1'b0, 24'h0, 1'b0);
        step();
        drive(4'h0, 24'h0, 1'b0, 24'h0, 1'b0);
        step();
        step();
        chk("to_start", 96'(start), 96'(1));
        chk("to_data",  96'(mdata), 96'(24'h42));
        for (int k = 0; k < 15; k++) step();
        chk("to_busy_before", 96'(busy), 96'(1));
        chk("to_flag_before", 96'(tmo),  96'(0));
        step();
`ifdef FIR_SCHED_TIMEOUT_EN
        chk("to_flag",  96'(tmo),  96'(1));
        chk("to_idle",  96'(busy), 96'(0));
        chk("to_res",   res,       96'(0));
        chk("to_rv",    96'(rv),   96'(0));
        // last_grant advanced to 0, so ch1 beats ch0; clear drops the flag meanwhile.
        drive(4'h3, 24'h50, 1'b0, 24'h0, 1'b1);
        step();
        chk("to_clear", 96'(tmo), 96'(0));
        drive(4'h0, 24'h0, 1'b0, 24'h0, 1'b0);
        step();
        step();
        chk("to_next_ch",   96'(mch),   96'(1));
        chk("to_next_data", 96'(mdata), 96'(24'h51));
        drive(4'h0, 24'h0, 1'b1, 24'h11, 1'b0);
        step();
        chk("to_next_rv", 96'(rv), 96'(4'h2));
`else
        for (int k = 0; k < 30; k++) step();
        chk("to_still_busy", 96'(busy), 96'(1));
        chk("to_flag_tied",  96'(tmo),  96'(0));
        drive(4'h0, 24'h0, 1'b1, 24'h11, 1'b0);
        step();
        chk("to_late_rv",  96'(rv),       96'(4'h1));
        chk("to_late_res", 96'(res[23:0]), 96'(24'h11));
`endif

        // Reset while a ch2 request is outstanding.
        do_reset();
        drive(4'h2, 24'h0, 1'b0, 24'h0, 1'b0);
        step();
        drive(4'h0, 24'h0, 1'b0, 24'h0, 1'b0);
        step();
        step();
        chk("rw_first_ch", 96'(mch), 96'(1));
        drive(4'h0, 24'h0, 1'b1, 24'h31, 1'b0);
        step();
        chk("rw_first_rv", 96'(rv), 96'(4'h2));
        drive(4'h4, 24'h0, 1'b0, 24'h0, 1'b0);
        step();
        drive(4'h0, 24'h0, 1'b0, 24'h0, 1'b0);
        step();
        step();
        chk("rw_second_ch", 96'(mch), 96'(2));
        reset_n = 1'b0;
        #2 chk_all_zero("rw_in_reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(4'h0, 24'h0, 1'b1, 24'h77, 1'b0);
        step();
        chk_all_zero("rw_after_done");
        drive(4'h5, 24'h60, 1'b0, 24'h0, 1'b0);
        step();
        drive(4'h0, 24'h0, 1'b0, 24'h0, 1'b0);
        step();
        step();
        chk("rw_next_start", 96'(start), 96'(1));
        chk("rw_next_ch",    96'(mch),   96'(0));
        chk("rw_next_data",  96'(mdata), 96'(24'h60));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
